// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serializes bitstream words onto a config-chain head.
// Define CCFF_READBACK_EN to add chain recirculation with CRC-16 verify.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 58,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int LW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
    localparam logic [LW-1:0] FULL = LW'(WORD_W);
    localparam logic [LW-1:0] ONE  = LW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [WORD_W-1:0] r_buf;
    logic [LW-1:0]     r_left;
    logic              w_start;
    logic              w_accept;
    logic              w_last;
    logic              w_load_shift;

    assign w_start      = (r_state == S_IDLE) && start;
    assign w_accept     = cfg_valid && cfg_ready;
    assign w_last       = (r_cnt == LAST);
    assign w_load_shift = (r_state == S_LOAD) && ccff_shift_en;
    assign busy         = (r_state != S_IDLE);

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (ccff_shift_en && w_last) begin
`ifdef CCFF_READBACK_EN
                    w_next = S_VERIFY;
`else
                    w_next = S_DONE;
`endif
                end
            end
            S_VERIFY: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // The refill on the last shifting bit is suppressed on the final chain bit
    always_comb begin
        cfg_ready     = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        done          = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                ccff_shift_en = (r_left != '0);
                ccff_head     = r_buf[0];
                cfg_ready     = (r_left == '0) || ((r_left == ONE) && !w_last);
            end
`ifdef CCFF_READBACK_EN
            S_VERIFY: begin
                ccff_shift_en = 1'b1;
                ccff_head     = ccff_tail;
            end
`endif
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_cnt  <= '0;
            r_buf  <= '0;
            r_left <= '0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
            end else if (ccff_shift_en) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_buf  <= cfg_data;
                r_left <= FULL;
            end else if (w_load_shift) begin
                if (w_last) begin
                    r_buf  <= '0;
                    r_left <= '0;
                end else begin
                    r_buf  <= r_buf >> 1;
                    r_left <= r_left - 1'b1;
                end
            end
        end
    end

`ifdef CCFF_READBACK_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    logic [15:0] r_crc_load;
    logic [15:0] r_crc_tail;
    logic [15:0] w_crc_tail_nx;
    logic        r_error;

    assign w_crc_tail_nx = crc_step(r_crc_tail, ccff_tail);
    assign error         = r_error;

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_crc_load <= 16'hFFFF;
            r_crc_tail <= 16'hFFFF;
            r_error    <= 1'b0;
        end else if (w_start) begin
            r_crc_load <= 16'hFFFF;
            r_crc_tail <= 16'hFFFF;
            r_error    <= 1'b0;
        end else if (w_load_shift) begin
            r_crc_load <= crc_step(r_crc_load, ccff_head);
        end else if (r_state == S_VERIFY) begin
            r_crc_tail <= w_crc_tail_nx;
            if (w_last) r_error <= (w_crc_tail_nx != r_crc_load);
        end
    end
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
    assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: random-word loads against a serial chain model.
// Works with and without CCFF_READBACK_EN defined.
module tb_ccff_bitstream_loader;
    localparam int CL  = 58;
    localparam int WW  = 8;
    localparam int NW  = (CL + WW - 1) / WW;
    localparam int CL2 = 16;
    localparam int WW2 = 16;
`ifdef CCFF_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    typedef logic [WW-1:0] words_t [NW];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, valid, ready, head, sh, tail, busy, done, err;
    logic [WW-1:0] data;
    logic start2, valid2, ready2, head2, sh2, tail2, busy2, done2, err2;
    logic [WW2-1:0] data2;

    logic [CL-1:0]  chain = '0;
    logic [CL-1:0]  chain_eff;
    logic           stuck = 1'b0;
    logic [CL2-1:0] chain2 = '0;

    assign chain_eff = stuck ? (chain | (CL'(1) << 20)) : chain;
    assign tail      = chain_eff[CL-1];
    assign tail2     = chain2[CL2-1];

    always @(posedge clk) if (sh) chain <= {chain_eff[CL-2:0], head};
    always @(posedge clk) if (sh2) chain2 <= {chain2[CL2-2:0], head2};

    ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk(clk), .pReset_n(rst_n), .start(start),
        .cfg_data(data), .cfg_valid(valid), .cfg_ready(ready),
        .ccff_head(head), .ccff_shift_en(sh), .ccff_tail(tail),
        .busy(busy), .done(done), .error(err)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(CL2), .WORD_W(WW2)) dut2 (
        .prog_clk(clk), .pReset_n(rst_n), .start(start2),
        .cfg_data(data2), .cfg_valid(valid2), .cfg_ready(ready2),
        .ccff_head(head2), .ccff_shift_en(sh2), .ccff_tail(tail2),
        .busy(busy2), .done(done2), .error(err2)
    );

    int   total = 0;
    int   bad = 0;
    bit   q_head[$];
    int   q_cyc[$];
    int   g_done;
    logic g_err_done;
    logic g_err_c1;

    // Stream bit i of a load is bit (i mod WW) of word i/WW, LSB first
    function automatic bit exp_bit(input words_t w, input int i);
        return w[i / WW][i % WW];
    endfunction

    task automatic rand_words(output words_t w);
        for (int i = 0; i < NW; i++) w[i] = WW'($urandom);
    endtask

    task automatic drive(input words_t w, input int stall_len, input int restart_at);
        int widx;
        int srem;
        bit stalled;
        widx = 0;
        srem = 0;
        stalled = 1'b0;
        q_head.delete();
        q_cyc.delete();
        g_done = -1;
        g_err_done = 1'bx;
        g_err_c1 = 1'bx;
        @(negedge clk);
        start = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) g_err_c1 = err;
            if (done) begin
                g_done = c;
                g_err_done = err;
                break;
            end
            if (sh) begin
                q_head.push_back(head);
                q_cyc.push_back(c);
            end
            if (c == restart_at) start = 1'b1;
            if (stall_len > 0 && !stalled && widx == 3 && ready) begin
                stalled = 1'b1;
                srem = stall_len;
            end
            valid = (widx < NW) && (srem == 0);
            if (srem > 0) srem--;
            data = '0;
            if (valid) data = w[widx];
            if (valid && ready) widx++;
            @(posedge clk);
        end
        valid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({ready, sh, head, busy, done, err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outs: got %b required 000000",
                     {ready, sh, head, busy, done, err});
        end
        total++;
        if ({ready2, sh2, head2, busy2, done2, err2} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outs2: got %b required 000000",
                     {ready2, sh2, head2, busy2, done2, err2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b1;
        data = 8'hFF;
        repeat (3) @(negedge clk);
        total++;
        if (ready !== 1'b0 || busy !== 1'b0 || sh !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_accept: ready=%b busy=%b sh=%b required 0 0 0",
                     ready, busy, sh);
        end
        valid = 1'b0;
    endtask

    task automatic test_full_rate;
        words_t w;
        int nerr;
        for (int i = 0; i < NW; i++) w[i] = 8'hA5;
        drive(w, 0, 0);
        total++;
        if (g_done != CL + 2 + RB * CL) begin
            bad++;
            $display("FAIL full_done: cycle %0d required %0d", g_done, CL + 2 + RB * CL);
        end
        total++;
        if (q_cyc.size() != CL * (1 + RB)) begin
            bad++;
            $display("FAIL full_nshift: %0d required %0d", q_cyc.size(), CL * (1 + RB));
        end
        total++;
        if (q_cyc.size() < CL || q_cyc[0] != 2 || q_cyc[CL-1] != CL + 1) begin
            bad++;
            $display("FAIL full_window: shifts not on edges 2..%0d", CL + 1);
        end
        nerr = 0;
        for (int i = 0; i < CL; i++)
            if (i >= q_head.size() || q_head[i] !== exp_bit(w, i)) nerr++;
        total++;
        if (nerr != 0) begin
            bad++;
            $display("FAIL full_head: %0d wrong bits, required 0", nerr);
        end
        nerr = 0;
        for (int j = 0; j < CL; j++)
            if (chain_eff[j] !== exp_bit(w, CL - 1 - j)) nerr++;
        total++;
        if (nerr != 0) begin
            bad++;
            $display("FAIL full_chain: %0d wrong stages, required 0", nerr);
        end
        total++;
        if (g_err_done !== 1'b0) begin
            bad++;
            $display("FAIL full_error: got %b required 0", g_err_done);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL full_after: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_stall;
        words_t w;
        int nerr;
        rand_words(w);
        drive(w, 3, 0);
        total++;
        if (g_done != CL + 5 + RB * CL) begin
            bad++;
            $display("FAIL stall_done: cycle %0d required %0d", g_done, CL + 5 + RB * CL);
        end
        total++;
        if (q_cyc.size() < CL || q_cyc[CL-1] - q_cyc[0] != CL + 2) begin
            bad++;
            $display("FAIL stall_gap: load shift window wrong, required span %0d", CL + 2);
        end
        nerr = 0;
        for (int i = 0; i < CL; i++)
            if (i >= q_head.size() || q_head[i] !== exp_bit(w, i)) nerr++;
        for (int j = 0; j < CL; j++)
            if (chain_eff[j] !== exp_bit(w, CL - 1 - j)) nerr++;
        total++;
        if (nerr != 0) begin
            bad++;
            $display("FAIL stall_data: %0d wrong bits, required 0", nerr);
        end
    endtask

    task automatic test_back_to_back;
        words_t w;
        int nerr;
        for (int k = 0; k < 3; k++) begin
            rand_words(w);
            drive(w, 0, 0);
            nerr = 0;
            for (int i = 0; i < CL; i++)
                if (i >= q_head.size() || q_head[i] !== exp_bit(w, i)) nerr++;
            for (int j = 0; j < CL; j++)
                if (chain_eff[j] !== exp_bit(w, CL - 1 - j)) nerr++;
            total++;
            if (nerr != 0 || g_done != CL + 2 + RB * CL || g_err_done !== 1'b0) begin
                bad++;
                $display("FAIL b2b_%0d: wrong=%0d done=%0d err=%b required 0 %0d 0",
                         k, nerr, g_done, g_err_done, CL + 2 + RB * CL);
            end
        end
    endtask

    task automatic test_readback_fault;
        words_t w;
        for (int i = 0; i < NW; i++) w[i] = '0;
        stuck = 1'b1;
        drive(w, 0, 0);
        total++;
        if (g_done != CL + 2 + RB * CL || g_err_done !== RB[0]) begin
            bad++;
            $display("FAIL fault_error: done=%0d err=%b required %0d %b",
                     g_done, g_err_done, CL + 2 + RB * CL, RB[0]);
        end
        repeat (5) @(negedge clk);
        total++;
        if (err !== RB[0]) begin
            bad++;
            $display("FAIL fault_sticky: err=%b required %b", err, RB[0]);
        end
        stuck = 1'b0;
        drive(w, 0, 0);
        total++;
        if (g_err_c1 !== 1'b0 || g_err_done !== 1'b0) begin
            bad++;
            $display("FAIL fault_clear: err_c1=%b err_done=%b required 0 0",
                     g_err_c1, g_err_done);
        end
    endtask

    task automatic test_reset_midload;
        words_t w;
        int n;
        int nerr;
        n = 0;
        @(negedge clk);
        start = 1'b1;
        valid = 1'b1;
        data = 8'hA5;
        @(posedge clk);
        for (int c = 1; c <= 200 && n < 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (sh) n++;
            if (n < 30) @(posedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (n != 30 || {ready, sh, head, busy, done, err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid: shifts=%0d outs=%b required 30 000000",
                     n, {ready, sh, head, busy, done, err});
        end
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rand_words(w);
        drive(w, 0, 20);
        nerr = 0;
        for (int i = 0; i < CL; i++)
            if (i >= q_head.size() || q_head[i] !== exp_bit(w, i)) nerr++;
        total++;
        if (nerr != 0 || q_cyc.size() == 0 || q_cyc[0] != 2) begin
            bad++;
            $display("FAIL restart_data: %0d wrong bits, required 0 from edge 2", nerr);
        end
        total++;
        if (g_done != CL + 2 + RB * CL) begin
            bad++;
            $display("FAIL busy_start: done=%0d required %0d", g_done, CL + 2 + RB * CL);
        end
    endtask

    task automatic test_params;
        bit h2[$];
        int d;
        int nerr;
        bit acc;
        d = -1;
        acc = 1'b0;
        @(negedge clk);
        start2 = 1'b1;
        valid2 = 1'b1;
        data2 = 16'h8001;
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (acc) valid2 = 1'b0;
            if (done2) begin
                d = c;
                break;
            end
            if (sh2) h2.push_back(head2);
            if (valid2 && ready2) acc = 1'b1;
            @(posedge clk);
        end
        valid2 = 1'b0;
        total++;
        if (d != CL2 + 2 + RB * CL2) begin
            bad++;
            $display("FAIL p_done: cycle %0d required %0d", d, CL2 + 2 + RB * CL2);
        end
        nerr = 0;
        for (int i = 0; i < CL2; i++)
            if (i >= h2.size() || h2[i] !== ((i == 0 || i == CL2 - 1) ? 1'b1 : 1'b0))
                nerr++;
        total++;
        if (nerr != 0 || h2.size() != CL2 * (1 + RB)) begin
            bad++;
            $display("FAIL p_head: %0d wrong bits, %0d shifts, required 0 %0d",
                     nerr, h2.size(), CL2 * (1 + RB));
        end
        total++;
        if (chain2 !== 16'h8001 || err2 !== 1'b0) begin
            bad++;
            $display("FAIL p_chain: chain=%h err=%b required 8001 0", chain2, err2);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        data = '0;
        start2 = 1'b0;
        valid2 = 1'b0;
        data2 = '0;
        test_reset();
        test_full_rate();
        test_stall();
        test_back_to_back();
        test_readback_fault();
        test_reset_midload();
        test_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
